// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_decoder
//  Brief    : Hard-decision Viterbi decoder, rate 1/2, K=3, generators 7/5
//             (octal). Four-state add-compare-select with register-exchange
//             survivor memory and a fixed decode latency of TB_LEN-1 symbols.
//  Revision : 1.0 - initial release
// ============================================================================
//
//  Encoder state is s = {a,b}: a is the previous data bit and b the one
//  before it. Data bit u from state {a,b} emits {u^a^b, u^b} and moves to
//  {u,a}, so destination state {u,a} is entered from {a,0} or {a,1}.
//
//  Survivors are register-exchanged: each state keeps the data bits of its
//  best path, newest in bit 0. Only the TB_LEN-1 youngest bits are stored;
//  the oldest bit of each freshly formed TB_LEN-bit survivor exists only
//  combinationally and is the one handed to d_out.
//
//  Metrics are normalised every step by subtracting the smallest new metric,
//  which keeps the spread tiny. The all-ones clamp is a guard that is never
//  reached for legal inputs.

module viterbi_decoder #(
  parameter int TB_LEN  = 24,  // survivor depth / decode latency (8..64)
  parameter int PM_W    = 8,   // path-metric width
  parameter int PM_INIT = 8    // starting metric of states 1..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  // Largest value a stored metric may take, in the wider arithmetic width.
  localparam logic [PM_W:0]   PM_SAT  = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] PM_RST1 = PM_W'(PM_INIT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PM_W-1:0]   pm_q   [4];
  logic [PM_W-1:0]   pm_d   [4];
  logic [TB_LEN-2:0] surv_q [4];
  logic [TB_LEN-2:0] surv_d [4];
  logic              d_out_q;
  logic              d_out_d;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [PM_W:0]     w_cand0    [4];  // candidate via predecessor {a,0}
  logic [PM_W:0]     w_cand1    [4];  // candidate via predecessor {a,1}
  logic              w_sel      [4];  // 1 = predecessor {a,1} won
  logic [PM_W:0]     w_metric   [4];  // selected, not yet normalised
  logic [PM_W:0]     w_norm     [4];  // after subtracting the minimum
  logic [TB_LEN-1:0] w_surv_new [4];  // full-depth survivor after this step
  logic [PM_W:0]     w_min;
  logic [1:0]        w_best;

  // Hamming distance between the received symbol and the symbol the
  // transition {a,b} --u--> {u,a} would have produced, widened for addition.
  function automatic logic [PM_W:0] bm_f(
    input logic [1:0] rx,
    input logic       u,
    input logic       a,
    input logic       b
  );
    logic [1:0] diff;
    diff = rx ^ {u ^ a ^ b, u ^ b};
    return {{(PM_W-1){1'b0}}, ({1'b0, diff[1]} + {1'b0, diff[0]})};
  endfunction

  // Add-compare-select per destination state; ties keep predecessor {a,0}.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      w_cand0[ns]    = {1'b0, pm_q[{ns[0], 1'b0}]} + bm_f(d_in, ns[1], ns[0], 1'b0);
      w_cand1[ns]    = {1'b0, pm_q[{ns[0], 1'b1}]} + bm_f(d_in, ns[1], ns[0], 1'b1);
      w_sel[ns]      = (w_cand1[ns] < w_cand0[ns]);
      w_metric[ns]   = w_sel[ns] ? w_cand1[ns] : w_cand0[ns];
      w_surv_new[ns] = {surv_q[{ns[0], w_sel[ns]}], ns[1]};
    end
  end

  // Smallest new metric and the state holding it; strict compare on an
  // ascending scan makes the lowest index win ties.
  always_comb begin
    w_min  = w_metric[0];
    w_best = 2'd0;
    for (int ns = 1; ns < 4; ns++) begin
      if (w_metric[ns] < w_min) begin
        w_min  = w_metric[ns];
        w_best = 2'(ns);
      end
    end
  end

  // Normalise, clamp, trim survivors to stored depth, pick the output bit.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      w_norm[ns] = w_metric[ns] - w_min;
      pm_d[ns]   = (w_norm[ns] > PM_SAT) ? {PM_W{1'b1}} : w_norm[ns][PM_W-1:0];
      surv_d[ns] = w_surv_new[ns][TB_LEN-2:0];
    end
    d_out_d = w_surv_new[w_best][TB_LEN-1];
  end

  // Register update: reset wins over enable; disabled cycles hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? {PM_W{1'b0}} : PM_RST1;
        surv_q[s] <= '0;
      end
      d_out_q <= 1'b0;
    end else if (enable) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= pm_d[s];
        surv_q[s] <= surv_d[s];
      end
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_decoder
//  Brief    : Self-checking bench for viterbi_decoder: reset/impulse vector
//             table, burst-error stream, enable gaps, mid-stream reset and a
//             long noisy run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_decoder;

  localparam int TB_LEN  = 24;
  localparam int PM_W    = 8;
  localparam int PM_INIT = 8;
  localparam int LAT     = TB_LEN - 1;
  localparam int NV      = 35;
  localparam int NB      = 256;
  localparam int NL      = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        r;
    logic        e;
    logic [1:0]  d;
    logic        exp_out;
    logic        chk_pm;
    logic [31:0] exp_pm;   // {pm3,pm2,pm1,pm0}
  } vec_t;

  vec_t       vt   [NV];
  logic       src  [NB];
  logic [1:0] rx   [NB];
  logic       lsrc [NL];
  logic [1:0] lrx  [NL];

  viterbi_decoder #(
    .TB_LEN (TB_LEN),
    .PM_W   (PM_W),
    .PM_INIT(PM_INIT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .d_in  (d_in),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pm_vec();
    return {dut.pm_q[3], dut.pm_q[2], dut.pm_q[1], dut.pm_q[0]};
  endfunction

  // Reference encoder: s = {a,b}
  function automatic logic [1:0] enc_out(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  // Apply one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] d);
    rst    = r;
    enable = e;
    d_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic make_stream(input int n, input bit burst);
    logic [1:0] s;
    s = 2'b00;
    for (int k = 0; k < n; k++) begin
      src[k] = 1'($urandom);
      rx[k]  = enc_out(src[k], s) ^ ((burst && (k % 16 < 2)) ? 2'b10 : 2'b00);
      s      = {src[k], s[1]};
    end
  endtask

  function automatic logic exp_bit(input int k);
    return (k >= LAT) ? src[k - LAT] : 1'b0;
  endfunction

  // Watchdog: guarantees termination even if the bench stalls.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int         k;
    int         guard;
    logic       last_exp;
    logic [1:0] s;
    logic [1:0] sym;
    int         cerr;
    int         derr;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] v;

    rst    = 1'b1;
    enable = 1'b0;
    d_in   = 2'b00;

    // ---------------- vector table: reset, hold, impulse ----------------
    for (int i = 0; i < NV; i++) begin
      vt[i].r       = (i < 3);
      vt[i].e       = (i < 3) || (i >= 5);
      vt[i].d       = 2'b11;
      vt[i].exp_out = 1'b0;
      vt[i].chk_pm  = (i < 5);
      vt[i].exp_pm  = 32'h0808_0800;
      if (i >= 5) begin
        case (i - 5)
          0:       vt[i].d = 2'b11;
          1:       vt[i].d = 2'b10;
          2:       vt[i].d = 2'b11;
          default: vt[i].d = 2'b00;
        endcase
        vt[i].exp_out = ((i - 5) == LAT);
      end
    end
    vt[5].chk_pm = 1'b1; vt[5].exp_pm = 32'h0900_0902;
    vt[6].chk_pm = 1'b1; vt[6].exp_pm = 32'h0203_0003;
    vt[7].chk_pm = 1'b1; vt[7].exp_pm = 32'h0302_0300;

    for (int i = 0; i < NV; i++) begin
      cyc(vt[i].r, vt[i].e, vt[i].d);
      check($sformatf("vec%0d_dout", i), {31'd0, d_out}, {31'd0, vt[i].exp_out});
      if (vt[i].chk_pm)
        check($sformatf("vec%0d_pm", i), pm_vec(), vt[i].exp_pm);
    end

    // ---------------- burst channel ----------------
    cyc(1'b1, 1'b0, 2'b00);
    make_stream(NB, 1'b1);
    for (int i = 0; i < NB; i++) begin
      cyc(1'b0, 1'b1, rx[i]);
      check($sformatf("burst_bit%0d", i), {31'd0, d_out}, {31'd0, exp_bit(i)});
    end

    // ---------------- enable gaps (same stream) ----------------
    cyc(1'b1, 1'b0, 2'b00);
    k        = 0;
    guard    = 0;
    last_exp = 1'b0;
    while (k < NB && guard < 4000) begin
      guard++;
      if ($urandom_range(99) < 30) begin
        cyc(1'b0, 1'b0, 2'($urandom));
        check($sformatf("gap_hold_at%0d", k), {31'd0, d_out}, {31'd0, last_exp});
      end else begin
        cyc(1'b0, 1'b1, rx[k]);
        last_exp = exp_bit(k);
        check($sformatf("gap_bit%0d", k), {31'd0, d_out}, {31'd0, last_exp});
        k++;
      end
    end
    check("gap_budget", k, NB);

    // ---------------- reset mid-stream ----------------
    cyc(1'b1, 1'b0, 2'b00);
    make_stream(101, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, rx[i]);
      check($sformatf("pre_rst_bit%0d", i), {31'd0, d_out}, {31'd0, exp_bit(i)});
    end
    cyc(1'b1, 1'b1, rx[100]);
    check("midrst_dout", {31'd0, d_out}, 32'd0);
    check("midrst_pm", pm_vec(), 32'h0808_0800);
    make_stream(120, 1'b0);
    for (int i = 0; i < 120; i++) begin
      cyc(1'b0, 1'b1, rx[i]);
      check($sformatf("post_rst_bit%0d", i), {31'd0, d_out}, {31'd0, exp_bit(i)});
    end

    // ---------------- long noisy run ----------------
    cyc(1'b1, 1'b0, 2'b00);
    s    = 2'b00;
    cerr = 0;
    for (int i = 0; i < NL; i++) begin
      lsrc[i] = 1'($urandom);
      sym     = enc_out(lsrc[i], s);
      s       = {lsrc[i], s[1]};
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(99) < 5) begin
          sym[b] = ~sym[b];
          cerr++;
        end
      end
      lrx[i] = sym;
    end
    derr = 0;
    for (int i = 0; i < NL; i++) begin
      cyc(1'b0, 1'b1, lrx[i]);
      mn = 8'hFF;
      mx = 8'h00;
      for (int j = 0; j < 4; j++) begin
        v = dut.pm_q[j];
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      check($sformatf("long_pm%0d", i), {30'd0, (mn == 8'h00), (mx != 8'hFF)}, 32'd3);
      if (i >= LAT && d_out !== lsrc[i - LAT]) derr++;
    end
    // Decoded BER (derr / NL) must sit well under channel BER (cerr / 2NL).
    check("long_ber", {31'd0, (derr * 4 < cerr)}, 32'd1);
    $display("long run: channel bit errors %0d, decoded bit errors %0d", cerr, derr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
